// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the memory-access / writeback stage: opcodes, FSM states,
// byte-enable patterns and reset/valid levels.
package mem_wb_stage_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ALU = 4'd1,
        OP_LW  = 4'd2,
        OP_LH  = 4'd3,
        OP_LHU = 4'd4,
        OP_LB  = 4'd5,
        OP_LBU = 4'd6,
        OP_SW  = 4'd7,
        OP_SH  = 4'd8,
        OP_SB  = 4'd9
    } op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    localparam logic VALID      = 1'b1;
    localparam logic INVALID    = 1'b0;
    localparam logic RST_ENABLE = 1'b0;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_SB);
    endfunction

    function automatic logic is_load_op(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_LBU);
    endfunction

    function automatic logic is_store_op(input logic [3:0] op);
        return (op >= OP_SW) && (op <= OP_SB);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store byte enables / replicated data, load extract and
// extend, and the alignment check, all from op and the low address bits.
module mem_align
    import mem_wb_stage_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic        misalign
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rdata[{lane, 3'b000} +: 8];
    assign rhalf = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be       = BE_NONE;
        wdata    = sdata;
        ldata    = rdata;
        misalign = 1'b0;
        case (op)
            OP_LW, OP_SW: begin
                be       = BE_WORD;
                misalign = (lane != 2'b00);
            end
            OP_LH, OP_LHU, OP_SH: begin
                be       = lane[1] ? BE_HALF_HI : BE_HALF_LO;
                misalign = lane[0];
                wdata    = {2{sdata[15:0]}};
                ldata    = (op == OP_LHU) ? {16'h0000, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            OP_LB, OP_LBU, OP_SB: begin
                be    = BE_BYTE0 << lane;
                wdata = {4{sdata[7:0]}};
                ldata = (op == OP_LBU) ? {24'h000000, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage: issues aligned loads/stores over a req/ack
// bus, stalls execute while busy, and drives a one-cycle register-file write.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_sdata,
    input  logic        ex_wreg,
    input  logic [4:0]  ex_waddr,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata,
    output logic        excpt_misalign,
    output logic        excpt_bus
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_e      state;
    logic [3:0]  op_q;
    logic [1:0]  lane_q;
    logic        wreg_q;
    logic [4:0]  waddr_q;
    logic [15:0] cnt;

    logic [3:0]  op_sel;
    logic [1:0]  lane_sel;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] ldata_c;
    logic        misalign_c;
    logic        accept;

    assign ex_ready = (state == ST_IDLE);
    assign accept   = ex_valid & ex_ready;

    // While an access is outstanding the aligner works on the captured op/lane.
    assign op_sel   = (state == ST_IDLE) ? ex_op : op_q;
    assign lane_sel = (state == ST_IDLE) ? ex_addr[1:0] : lane_q;

    mem_align u_align (
        .op       (op_sel),
        .lane     (lane_sel),
        .sdata    (ex_sdata),
        .rdata    (dm_rdata),
        .be       (be_c),
        .wdata    (wdata_c),
        .ldata    (ldata_c),
        .misalign (misalign_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state          <= ST_IDLE;
            dm_req         <= INVALID;
            dm_we          <= 1'b0;
            dm_addr        <= '0;
            dm_be          <= '0;
            dm_wdata       <= '0;
            we             <= INVALID;
            waddr          <= '0;
            wdata          <= '0;
            excpt_misalign <= 1'b0;
            excpt_bus      <= 1'b0;
            op_q           <= '0;
            lane_q         <= '0;
            wreg_q         <= 1'b0;
            waddr_q        <= '0;
            cnt            <= '0;
        end else begin
            we             <= INVALID;
            excpt_misalign <= 1'b0;
            excpt_bus      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && ex_op == OP_ALU) begin
                        we    <= ex_wreg;
                        waddr <= ex_waddr;
                        wdata <= ex_addr;
                    end else if (accept && is_mem_op(ex_op)) begin
                        if (misalign_c) begin
                            excpt_misalign <= 1'b1;
                        end else begin
                            dm_req   <= VALID;
                            dm_we    <= is_store_op(ex_op);
                            dm_addr  <= {ex_addr[31:2], 2'b00};
                            dm_be    <= be_c;
                            dm_wdata <= wdata_c;
                            op_q     <= ex_op;
                            lane_q   <= ex_addr[1:0];
                            wreg_q   <= ex_wreg;
                            waddr_q  <= ex_waddr;
                            cnt      <= '0;
                            state    <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Ack wins over timeout when both land on the same cycle.
                    if (dm_ack) begin
                        dm_req <= INVALID;
                        state  <= ST_IDLE;
                        if (is_load_op(op_q)) begin
                            we    <= wreg_q;
                            waddr <= waddr_q;
                            wdata <= ldata_c;
                        end
                    end else if (cnt == CNT_LAST) begin
                        dm_req    <= INVALID;
                        excpt_bus <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_wb_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_sdata;
    logic        ex_wreg;
    logic [4:0]  ex_waddr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        excpt_misalign;
    logic        excpt_bus;

    int checks = 0;
    int failures = 0;

    mem_wb_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_addr(ex_addr), .ex_sdata(ex_sdata), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .excpt_misalign(excpt_misalign), .excpt_bus(excpt_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction view) ----------------
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd2, 4'd7:       return 4;
            4'd3, 4'd4, 4'd8: return 2;
            4'd5, 4'd6, 4'd9: return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [3:0] be_of(input int sz, input logic [31:0] a);
        int m;
        m = ((1 << sz) - 1) << (a % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] rep_of(input int sz, input logic [31:0] d);
        if (sz == 1) return {4{d[7:0]}};
        if (sz == 2) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] load_of(input logic [3:0] op, input int lane, input logic [31:0] rd);
        logic [31:0] v;
        int sz;
        sz = op_size(op);
        v = rd >> (8 * lane);
        if (sz == 1) begin
            v = v & 32'hFF;
            if (op == 4'd5 && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
            v = v & 32'hFFFF;
            if (op == 4'd3 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    logic        m_busy;
    int          m_age;
    logic [3:0]  m_op;
    int          m_lane;
    logic        m_wreg;
    logic [4:0]  m_waddr;
    logic        e_req, e_dmwe, e_we, e_mis, e_bus;
    logic [31:0] e_addr, e_dwd, e_wdata;
    logic [3:0]  e_be;
    logic [4:0]  e_waddr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0; m_age <= 0; m_op <= '0; m_lane <= 0; m_wreg <= 1'b0; m_waddr <= '0;
            e_req <= 1'b0; e_dmwe <= 1'b0; e_addr <= '0; e_be <= '0; e_dwd <= '0;
            e_we <= 1'b0; e_waddr <= '0; e_wdata <= '0; e_mis <= 1'b0; e_bus <= 1'b0;
        end else begin
            e_we  <= 1'b0;
            e_mis <= 1'b0;
            e_bus <= 1'b0;
            if (!m_busy) begin
                if (ex_valid && ex_op == 4'd1) begin
                    e_we <= ex_wreg; e_waddr <= ex_waddr; e_wdata <= ex_addr;
                end else if (ex_valid && op_size(ex_op) != 0) begin
                    if ((ex_addr % op_size(ex_op)) != 0) begin
                        e_mis <= 1'b1;
                    end else begin
                        m_busy  <= 1'b1;
                        m_age   <= 1;
                        m_op    <= ex_op;
                        m_lane  <= int'(ex_addr % 4);
                        m_wreg  <= ex_wreg;
                        m_waddr <= ex_waddr;
                        e_req   <= 1'b1;
                        e_dmwe  <= (ex_op >= 4'd7);
                        e_addr  <= ex_addr & ~32'd3;
                        e_be    <= be_of(op_size(ex_op), ex_addr);
                        e_dwd   <= rep_of(op_size(ex_op), ex_sdata);
                    end
                end
            end else if (dm_ack) begin
                m_busy <= 1'b0;
                e_req  <= 1'b0;
                if (m_op <= 4'd6) begin
                    e_we <= m_wreg; e_waddr <= m_waddr; e_wdata <= load_of(m_op, m_lane, dm_rdata);
                end
            end else if (m_age == TO) begin
                m_busy <= 1'b0;
                e_req  <= 1'b0;
                e_bus  <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("ex_ready", 32'(ex_ready), 32'(!m_busy));
        chk("dm_req", 32'(dm_req), 32'(e_req));
        chk("dm_we", 32'(dm_we), 32'(e_dmwe));
        chk("dm_addr", dm_addr, e_addr);
        chk("dm_be", 32'(dm_be), 32'(e_be));
        chk("dm_wdata", dm_wdata, e_dwd);
        chk("we", 32'(we), 32'(e_we));
        chk("waddr", 32'(waddr), 32'(e_waddr));
        chk("wdata", wdata, e_wdata);
        chk("excpt_misalign", 32'(excpt_misalign), 32'(e_mis));
        chk("excpt_bus", 32'(excpt_bus), 32'(e_bus));
    end

    // ---------------- stimulus ----------------
    task automatic cyc;
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] wa);
        ex_valid = 1'b1; ex_op = op; ex_addr = a; ex_sdata = sd; ex_wreg = 1'b1; ex_waddr = wa;
        cyc();
        ex_valid = 1'b0;
    endtask

    initial begin
        int req_cycles;
        int bus_pulses;
        rst = 1'b0;
        ex_valid = 1'b0; ex_op = '0; ex_addr = '0; ex_sdata = '0; ex_wreg = 1'b0; ex_waddr = '0;
        dm_ack = 1'b0; dm_rdata = '0;
        cyc(); cyc();
        chk("rst_dm_req", 32'(dm_req), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        rst = 1'b1;
        cyc();

        // ALU pass-through
        issue(4'd1, 32'h1234_5678, 32'h0, 5'd5);
        chk("alu_we", 32'(we), 32'd1);
        chk("alu_waddr", 32'(waddr), 32'd5);
        chk("alu_wdata", wdata, 32'h1234_5678);
        cyc();
        chk("alu_we_pulse", 32'(we), 32'd0);
        chk("alu_wdata_hold", wdata, 32'h1234_5678);

        // LB / LBU on lane 3, ack on the first request cycle
        for (int k = 0; k < 2; k++) begin
            issue(k == 0 ? 4'd5 : 4'd6, 32'h0000_0103, 32'h0, 5'd7);
            chk("lb_dm_req", 32'(dm_req), 32'd1);
            chk("lb_dm_addr", dm_addr, 32'h100);
            chk("lb_dm_be", 32'(dm_be), 32'b1000);
            chk("lb_dm_we", 32'(dm_we), 32'd0);
            dm_ack = 1'b1; dm_rdata = 32'h80FF_0000;
            cyc();
            dm_ack = 1'b0;
            chk("lb_req_drop", 32'(dm_req), 32'd0);
            chk("lb_we", 32'(we), 32'd1);
            chk("lb_wdata", wdata, k == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
            chk("lb_ready", 32'(ex_ready), 32'd1);
        end

        // SH on upper half, three wait cycles
        issue(4'd8, 32'h0000_0202, 32'hAAAA_BEEF, 5'd9);
        chk("sh_dm_wdata", dm_wdata, 32'hBEEF_BEEF);
        chk("sh_dm_be", 32'(dm_be), 32'b1100);
        chk("sh_dm_we", 32'(dm_we), 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("sh_wait_req", 32'(dm_req), 32'd1);
            chk("sh_wait_ready", 32'(ex_ready), 32'd0);
        end
        dm_ack = 1'b1;
        cyc();
        dm_ack = 1'b0;
        chk("sh_no_we", 32'(we), 32'd0);
        chk("sh_ready", 32'(ex_ready), 32'd1);
        chk("sh_req_drop", 32'(dm_req), 32'd0);

        // Misaligned LW
        issue(4'd2, 32'h0000_0301, 32'h0, 5'd3);
        chk("mis_pulse", 32'(excpt_misalign), 32'd1);
        chk("mis_no_req", 32'(dm_req), 32'd0);
        chk("mis_no_we", 32'(we), 32'd0);
        chk("mis_ready", 32'(ex_ready), 32'd1);
        cyc();
        chk("mis_pulse_end", 32'(excpt_misalign), 32'd0);

        // Timeout: no ack ever
        issue(4'd2, 32'h0000_0400, 32'h0, 5'd4);
        req_cycles = 0;
        bus_pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (dm_req) req_cycles++;
            if (excpt_bus) bus_pulses++;
            cyc();
        end
        chk("to_req_cycles", 32'(req_cycles), 32'(TO));
        chk("to_bus_pulses", 32'(bus_pulses), 32'd1);
        chk("to_no_we", 32'(we), 32'd0);
        issue(4'd1, 32'hCAFE_0001, 32'h0, 5'd6);
        chk("to_alu_we", 32'(we), 32'd1);
        chk("to_alu_wdata", wdata, 32'hCAFE_0001);

        // Async reset while an access is outstanding
        issue(4'd2, 32'h0000_0500, 32'h0, 5'd8);
        chk("ar_req", 32'(dm_req), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("ar_req_drop", 32'(dm_req), 32'd0);
        chk("ar_ready", 32'(ex_ready), 32'd1);
        cyc();
        rst = 1'b1;
        dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
        cyc();
        dm_ack = 1'b0;
        chk("ar_late_ack_we", 32'(we), 32'd0);
        chk("ar_late_ack_req", 32'(dm_req), 32'd0);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            ex_valid = ($urandom_range(0, 9) < 7);
            ex_op    = 4'($urandom_range(0, 15));
            ex_addr  = $urandom;
            if ($urandom_range(0, 3) != 0) ex_addr[1:0] = 2'b00;
            ex_sdata = $urandom;
            ex_wreg  = ($urandom_range(0, 3) != 0);
            ex_waddr = 5'($urandom);
            dm_ack   = ($urandom_range(0, 9) < 4);
            dm_rdata = $urandom;
            cyc();
        end
        ex_valid = 1'b0;
        dm_ack = 1'b0;
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and writeback stage of the pipeline, directly upstream of the register file write port (we/waddr/wdata).
- Accepts one instruction result from execute and performs any load/store over a req/ack data-memory interface with byte-lane alignment.
- Drives a registered, single-cycle write into the register file.
- Stalls execute while a memory access is outstanding; flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: max cycles dm_req stays high without dm_ack before abort (1..65535).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low (rst==0 resets immediately)
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage can accept this cycle
- ex_op  in  4  0 NOP, 1 ALU, 2 LW, 3 LH, 4 LHU, 5 LB, 6 LBU, 7 SW, 8 SH, 9 SB; others treated as NOP
- ex_addr  in  32  ALU result (ALU) or effective address (mem ops)
- ex_sdata  in  32  store data
- ex_wreg  in  1  instruction writes a register
- ex_waddr  in  5  destination register
- dm_req  out  1  memory request
- dm_we  out  1  1 = store
- dm_addr  out  32  word-aligned address {ex_addr[31:2],2'b00}
- dm_be  out  4  byte enables
- dm_wdata  out  32  lane-replicated store data
- dm_ack  in  1  memory completes request (sampled when dm_req=1)
- dm_rdata  in  32  load data, valid with dm_ack
- we  out  1  register write pulse
- waddr  out  5  register write address
- wdata  out  32  register write data
- excpt_misalign  out  1  one-cycle pulse, misaligned access
- excpt_bus  out  1  one-cycle pulse, memory timeout

Behaviour:
- Reset (async, rst==0): state IDLE; dm_req, dm_we, we, excpt_* = 0; dm_addr, dm_be, dm_wdata, waddr, wdata, timeout counter = 0. Reset mid-access drops dm_req in the same cycle; the access is abandoned and no write occurs.
- States: IDLE, ACCESS. ex_ready = (state==IDLE), combinational.
- Accept = ex_valid & ex_ready.
- IDLE, accept of ALU: next cycle we=ex_wreg, waddr=ex_waddr, wdata=ex_addr. Latency 1.
- IDLE, accept of NOP or unknown op: no action.
- IDLE, accept of mem op, aligned: next cycle dm_req=1 with dm_addr/dm_be/dm_wdata/dm_we registered; state becomes ACCESS; counter cleared; waddr/op/lane/wreg captured.
- Misalignment: LW/SW require addr[1:0]==0; LH/LHU/SH require addr[0]==0. A misaligned op pulses excpt_misalign next cycle, issues no request and no write, and stays IDLE.
- Store lanes (little-endian; lane 0 = bits 7:0):
  - SW: be=1111, data unchanged.
  - SH: data={2{sdata[15:0]}}, be=addr[1]?1100:0011.
  - SB: data={4{sdata[7:0]}}, be=0001<<addr[1:0].
- Load be: loads use the same byte enables as stores of the same size; dm_we=0.
- ACCESS: dm_req and all dm_* outputs held stable until dm_ack is sampled high. Ack may arrive on the first cycle dm_req is high.
- On ack: dm_req=0 next cycle; state IDLE.
  - Load: we=ex_wreg captured, wdata = aligned data, 1 cycle after ack.
  - Store: no write.
- Load alignment: LB/LBU select byte addr[1:0] and sign-/zero-extend; LH/LHU select half addr[1] and extend; LW passes through.
- Timeout: the counter increments each ACCESS cycle without ack. When it reaches TIMEOUT, the stage drops dm_req, pulses excpt_bus, returns to IDLE, and performs no write.
- dm_ack while IDLE is ignored.
- Hold behaviour: we is a 1-cycle pulse; waddr/wdata hold their last value otherwise. The x0 filter is the register file's job; this stage passes waddr=0 unchanged.
- Best-case throughput: ALU 1/cycle; memory op 2 cycles (accept, req+ack), next accept in the ack+1 cycle.

Decomposition:
- Shared package/define file holds:
  - ex_op encodings
  - state encodings
  - byte-enable patterns
  - Valid/RstEnable-style constants, extended with an active-low reset level
- One natural sub-module: mem_align, purely combinational. It computes store be/data and load extract/extend from op, addr[1:0], and data.
- The FSM, counter and registers stay in mem_wb_stage.

Test Plan:
- ALU pass: ex_op=1, addr=0x1234_5678, waddr=5 -> next cycle we=1, waddr=5, wdata=0x12345678, then we=0.
- LB sign: op=LB, addr=0x103, rdata=0x80FF_0000 with ack in the first req cycle -> dm_addr=0x100, dm_be=1000, then wdata=0xFFFFFF80; the same access with LBU -> 0x00000080.
- SH lanes: op=SH, addr=0x202, sdata=0xAAAA_BEEF -> dm_wdata=0xBEEFBEEF, dm_be=1100, dm_we=1; ack after 3 wait cycles -> no we, ex_ready low until ack cycle+1.
- Misalign: op=LW, addr=0x301 -> excpt_misalign pulse, dm_req never asserted, we=0, ex_ready stays 1.
- Timeout: TIMEOUT=4, op=LW, no ack -> dm_req high 4 cycles, excpt_bus pulse, then IDLE; a subsequent ALU op completes normally.
- Async reset mid-ACCESS: drop rst low between clock edges -> dm_req=0 immediately; after release, a late dm_ack is ignored and no write occurs.
